// File: rtl/player_packet_rx.sv
// 8N1 UART deframer for 6-byte player packets; record/errors appear one clock after the final stop-bit sample.
// No backpressure: every pulse is single-cycle and the pkt_* fields hold until the next good packet.
module player_packet_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_CLKS = 20000
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       rx_in,
  output logic       pkt_valid,
  output logic [1:0] pkt_player_id,
  output logic [1:0] pkt_direction,
  output logic [8:0] pkt_loc_x,
  output logic [8:0] pkt_loc_y,
  output logic [3:0] pkt_state,
  output logic       frame_err,
  output logic       chk_err,
  output logic       timeout_err
);

  localparam int CW = 12;
  localparam int GW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [GW-1:0] GAP_M1  = GW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]    SYNC    = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic {HUNT, COLLECT} asm_state_e;

  rx_state_e   rx_st_q;
  asm_state_e  asm_st_q;
  logic          rx_meta_q, rx_sync_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic [GW-1:0] gap_q;
  logic [2:0]    idx_q;
  logic [7:0]    xor_q, b1_q, b2_q, b3_q;
  logic [1:0]    b4_hi_q;
  logic          pkt_valid_q, frame_err_q, chk_err_q, timeout_err_q;
  logic [1:0]    id_q, dir_q;
  logic [8:0]    loc_x_q, loc_y_q;
  logic [3:0]    state_q;

  // The stop-bit sample cycle: the byte is complete in shift_q and the assembler acts on it here.
  logic stop_tick, byte_acc, byte_bad;
  assign stop_tick = (rx_st_q == RX_STOP) && (cnt_q == FULL_M1);
  assign byte_acc  = stop_tick && rx_sync_q;
  assign byte_bad  = stop_tick && !rx_sync_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_st_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
    end else begin
      rx_meta_q <= rx_in;
      rx_sync_q <= rx_meta_q;
      unique case (rx_st_q)
        RX_IDLE: begin
          cnt_q <= '0;
          bit_q <= '0;
          if (!rx_sync_q) rx_st_q <= RX_START;
        end
        RX_START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q   <= '0;
            rx_st_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + 12'd1;
          end
        end
        RX_DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            shift_q <= {rx_sync_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) rx_st_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + 12'd1;
          end
        end
        RX_STOP: begin
          if (stop_tick) begin
            cnt_q   <= '0;
            rx_st_q <= RX_IDLE;
          end else begin
            cnt_q <= cnt_q + 12'd1;
          end
        end
        default: rx_st_q <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      asm_st_q      <= HUNT;
      gap_q         <= '0;
      idx_q         <= '0;
      xor_q         <= '0;
      b1_q          <= '0;
      b2_q          <= '0;
      b3_q          <= '0;
      b4_hi_q       <= '0;
      pkt_valid_q   <= 1'b0;
      frame_err_q   <= 1'b0;
      chk_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      id_q          <= '0;
      dir_q         <= '0;
      loc_x_q       <= '0;
      loc_y_q       <= '0;
      state_q       <= '0;
    end else begin
      pkt_valid_q   <= 1'b0;
      frame_err_q   <= 1'b0;
      chk_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      if (byte_bad) begin
        frame_err_q <= 1'b1;
        asm_st_q    <= HUNT;
      end else if (byte_acc) begin
        gap_q <= '0;
        if (asm_st_q == HUNT) begin
          if (shift_q == SYNC) begin
            asm_st_q <= COLLECT;
            idx_q    <= 3'd1;
            xor_q    <= '0;
          end
        end else if (idx_q == 3'd5) begin
          asm_st_q <= HUNT;
          if (shift_q == xor_q) begin
            pkt_valid_q <= 1'b1;
            id_q        <= b1_q[7:6];
            dir_q       <= b1_q[5:4];
            state_q     <= b1_q[3:0];
            loc_x_q     <= {b4_hi_q[1], b2_q};
            loc_y_q     <= {b4_hi_q[0], b3_q};
          end else begin
            chk_err_q <= 1'b1;
          end
        end else begin
          xor_q <= xor_q ^ shift_q;
          idx_q <= idx_q + 3'd1;
          unique case (idx_q)
            3'd1:    b1_q    <= shift_q;
            3'd2:    b2_q    <= shift_q;
            3'd3:    b3_q    <= shift_q;
            default: b4_hi_q <= shift_q[7:6];
          endcase
        end
      end else if (asm_st_q == COLLECT) begin
        if (gap_q == GAP_M1) begin
          timeout_err_q <= 1'b1;
          asm_st_q      <= HUNT;
          gap_q         <= '0;
        end else begin
          gap_q <= gap_q + GW'(1);
        end
      end
    end
  end

  assign pkt_valid     = pkt_valid_q;
  assign frame_err     = frame_err_q;
  assign chk_err       = chk_err_q;
  assign timeout_err   = timeout_err_q;
  assign pkt_player_id = id_q;
  assign pkt_direction = dir_q;
  assign pkt_loc_x     = loc_x_q;
  assign pkt_loc_y     = loc_y_q;
  assign pkt_state     = state_q;

endmodule

// File: doc/player_packet_rx.md
# player_packet_rx

Serial receive-side deframer for the inter-FPGA player link: recovers 8N1 UART bytes from the RX pin, assembles fixed 6-byte player-update packets, checks them, and presents one validated player record per packet. Sits between the RX pin (ja_1) and the per-player direction/location/state registers feeding game logic and graphics. It is the counterpart of the link's packet transmitter and accepts exactly the frames that transmitter emits.

## Interface
- CLKS_PER_BIT, default 868: clocks per UART bit (100 MHz / 115200); legal range 8..4095.
- TIMEOUT_CLKS, default 20000: maximum idle clocks between bytes inside a packet.
- clk_in  input  1  system clock, 100 MHz.
- rst_n_in  input  1  reset, asynchronous, active-low.
- rx_in  input  1  raw serial line; idle high; asynchronous to clk_in.
- pkt_valid  output  1  one-cycle pulse: new validated record on pkt_* outputs.
- pkt_player_id  output  2  player index 0..3.
- pkt_direction  output  2  facing direction.
- pkt_loc_x  output  9  x location.
- pkt_loc_y  output  9  y location.
- pkt_state  output  4  player state.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- chk_err  output  1  one-cycle pulse: checksum mismatch.
- timeout_err  output  1  one-cycle pulse: inter-byte gap exceeded mid-packet.

## Operation
- Packet, bytes in order, each 8N1, LSB first: B0 = 0xA5 sync; B1 = {id[1:0], dir[1:0], state[3:0]}; B2 = loc_x[7:0]; B3 = loc_y[7:0]; B4 = {loc_x[8], loc_y[8], 6'b0}; B5 = B1^B2^B3^B4.
- Byte receiver: rx_in passes a 2-flop synchronizer, both flops reset to 1. States IDLE, START, DATA, STOP.
  - IDLE: synchronized rx = 0 -> START, bit counter cleared.
  - START: after CLKS_PER_BIT/2 clocks (integer divide), sample; 0 -> DATA; 1 -> IDLE (glitch, no error).
  - DATA: sample every CLKS_PER_BIT clocks, shift in LSB first; after 8th sample -> STOP.
  - STOP: after CLKS_PER_BIT clocks sample; 1 -> byte accepted; 0 -> frame_err pulse, byte discarded. Both -> IDLE immediately (no wait for full stop bit).
- Packet assembler: states HUNT, COLLECT.
  - HUNT: accepted byte 0xA5 -> COLLECT, index = 1, running XOR cleared; any other byte ignored.
  - COLLECT: indices 1..4 stored and XORed; index 5 compared to XOR. Match -> outputs updated, pkt_valid pulse; mismatch -> chk_err pulse, outputs unchanged. Either -> HUNT.
  - 0xA5 inside COLLECT is payload, not resync.
  - frame_err in COLLECT -> HUNT, partial packet discarded.
  - Gap counter counts clocks since last accepted byte while in COLLECT; reaching TIMEOUT_CLKS -> timeout_err pulse, HUNT. Cleared on every accepted byte.
- B4[5:0] ignored except in checksum.
- pkt_* hold last valid record until next valid packet.

## Timing
- Reset: all outputs 0; byte receiver IDLE; assembler HUNT; counters 0. Assertion mid-byte or mid-packet aborts all; first packet after release must start with a fresh start bit.
- Synchronizer latency 2 clocks from rx_in edge.
- Data bit k sampled (CLKS_PER_BIT/2) + (k+1)*CLKS_PER_BIT clocks after detected start edge, k = 0..7; stop bit at +9*CLKS_PER_BIT.
- pkt_valid, chk_err, frame_err: registered, asserted the clock after the relevant stop-bit sample; pkt_* change in that same cycle.
- Error and valid pulses are mutually exclusive in any cycle.
- Back-to-back bytes with zero idle between stop and next start are received without loss.
- Counter widths cover max parameter; no wrap in legal range.

## Test plan
- CLKS_PER_BIT=16: send A5, 9E, 34, 7F, C0, 15 (checksum 9E^34^7F^C0=15) -> single pkt_valid; id=2, dir=1, state=0xE, loc_x=0x134, loc_y=0x17F.
- Same packet with B5=0x16 -> chk_err pulse, no pkt_valid, outputs keep previous values.
- Bytes 00, 42, then valid packet back-to-back -> leading bytes ignored in HUNT, one pkt_valid with correct fields.
- Drive stop bit of B3 low -> frame_err; next valid packet decodes correctly.
- TIMEOUT_CLKS=500: send A5, 9E, idle 600 clocks -> timeout_err at clock 500 after B1 accepted; next full packet valid.
- 4-clock low glitch on idle line -> no error, no byte; rst_n_in low for 3 clocks mid-B2 -> all outputs 0, subsequent packet decodes.
